// File: rtl/uart_cmd_engine.sv
// uart_cmd_engine
// Byte-level host command engine between the UART receiver and transmitter.
// Single-byte commands: 't' toggles the LED, 's' stores a secret of up to
// DEPTH bytes (ended by CR, by filling the buffer, or by an idle timeout),
// 'g' replays exactly the stored length, 0x1B pulses the target reset low.
// Any other byte received while idle is echoed back when ECHO_EN is set.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   rx_valid      one-cycle strobe qualifying rx_data
//   rx_data       received byte
//   tx_rdy        transmitter idle
//   tx_en         one-cycle transmit strobe
//   tx_data       byte to transmit, stable while tx_en is high
//   led           LED state
//   target_rst_n  active-low reset pulse to the target board
//   busy          high whenever the engine is not idle
//   len           currently stored secret length
module uart_cmd_engine #(
  parameter int DEPTH     = 16,
  parameter int TIMEOUT   = 32000000,
  parameter int RST_PULSE = 16,
  parameter int ECHO_EN   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  input  logic                       tx_rdy,
  output logic                       tx_en,
  output logic [7:0]                 tx_data,
  output logic                       led,
  output logic                       target_rst_n,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] len
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(RST_PULSE + 1);

  localparam logic [LW-1:0] WPTR_LAST = LW'(DEPTH - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(RST_PULSE - 1);

  localparam logic [7:0] CMD_TOGGLE = 8'h74;
  localparam logic [7:0] CMD_SET    = 8'h73;
  localparam logic [7:0] CMD_GET    = 8'h67;
  localparam logic [7:0] CMD_RESET  = 8'h1B;
  localparam logic [7:0] CHR_CR     = 8'h0D;
  localparam logic [7:0] CHR_ACK    = 8'h4B;

  typedef enum logic [2:0] {S_IDLE, S_SET, S_ACK, S_GET, S_ECHO} state_t;

  // Power-on secret is "ABCD..."; rst never touches the buffer.
  function automatic logic [DEPTH-1:0][7:0] init_mem();
    logic [DEPTH-1:0][7:0] m;
    for (int i = 0; i < DEPTH; i++) m[i] = 8'h41 + 8'(i);
    return m;
  endfunction

  logic [DEPTH-1:0][7:0] mem_q = init_mem();

  state_t          state_q, state_nxt;
  logic [LW-1:0]   wptr_q, rptr_q;
  logic [TW-1:0]   tcnt_q;
  logic [PW-1:0]   pcnt_q;
  logic [1:0]      guard_q;
  logic [7:0]      echo_q;
  logic            send_ok, issue, idle_rx, set_wr;
  logic [7:0]      tx_byte;

  // Transmitter ready is ignored for two clocks after each strobe because
  // the UART drops tx_rdy with some lag.
  assign send_ok = tx_rdy && (guard_q == 2'd0);
  assign idle_rx = (state_q == S_IDLE) && rx_valid;
  assign set_wr  = (state_q == S_SET) && rx_valid && (rx_data != CHR_CR);
  assign busy    = (state_q != S_IDLE);

  // ---- next-state / transmit request ----
  always_comb begin
    state_nxt = state_q;
    issue     = 1'b0;
    tx_byte   = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_SET:               state_nxt = S_SET;
            CMD_GET:               if (len != '0) state_nxt = S_GET;
            CMD_TOGGLE, CMD_RESET: state_nxt = S_IDLE;
            default:               if (ECHO_EN != 0) state_nxt = S_ECHO;
          endcase
        end
      end
      S_SET: begin
        if (rx_valid) begin
          // Byte has priority over a simultaneous timeout expiry.
          if (rx_data == CHR_CR || wptr_q == WPTR_LAST) state_nxt = S_ACK;
        end else if (tcnt_q == TCNT_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      S_ACK: begin
        tx_byte = CHR_ACK;
        issue   = send_ok;
        if (tx_en) state_nxt = S_IDLE;
      end
      S_ECHO: begin
        tx_byte = echo_q;
        issue   = send_ok;
        if (tx_en) state_nxt = S_IDLE;
      end
      S_GET: begin
        tx_byte = mem_q[rptr_q[AW-1:0]];
        issue   = send_ok && (rptr_q != len);
        // Leave only once the last strobe is on the wire so busy drops after it.
        if (tx_en && rptr_q == len) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  // ---- control registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en        <= 1'b0;
      tx_data      <= 8'h00;
      guard_q      <= 2'd0;
      led          <= 1'b0;
      target_rst_n <= 1'b1;
      pcnt_q       <= '0;
      len          <= LW'(DEPTH);
      wptr_q       <= '0;
      rptr_q       <= '0;
      tcnt_q       <= '0;
    end else begin
      tx_en <= issue;
      if (issue) begin
        tx_data <= tx_byte;
        guard_q <= 2'd2;
      end else if (guard_q != 2'd0) begin
        guard_q <= guard_q - 2'd1;
      end

      if (idle_rx && rx_data == CMD_TOGGLE) led <= ~led;

      // Low for exactly RST_PULSE clocks; a repeat command restarts it.
      if (idle_rx && rx_data == CMD_RESET) begin
        target_rst_n <= 1'b0;
        pcnt_q       <= PCNT_LAST;
      end else if (!target_rst_n) begin
        if (pcnt_q == '0) target_rst_n <= 1'b1;
        else              pcnt_q       <= pcnt_q - PW'(1);
      end

      if (idle_rx && rx_data == CMD_SET) begin
        wptr_q <= '0;
        tcnt_q <= '0;
      end
      if (idle_rx && rx_data == CMD_GET) rptr_q <= '0;
      if (state_q == S_GET && issue) rptr_q <= rptr_q + LW'(1);

      if (state_q == S_SET) begin
        if (rx_valid) begin
          tcnt_q <= '0;
          if (rx_data == CHR_CR) begin
            len <= wptr_q;
          end else begin
            wptr_q <= wptr_q + LW'(1);
            if (wptr_q == WPTR_LAST) len <= LW'(DEPTH);
          end
        end else if (tcnt_q == TCNT_LAST) begin
          len <= wptr_q;
        end else begin
          tcnt_q <= tcnt_q + TW'(1);
        end
      end
    end
  end

  // ---- data registers (no reset) ----
  always_ff @(posedge clk) begin
    if (idle_rx) echo_q <= rx_data;
    if (set_wr)  mem_q[wptr_q[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Directed bench for uart_cmd_engine (DEPTH=16, TIMEOUT=100, RST_PULSE=16).
module tb_uart_cmd_engine;

  localparam int DEPTH     = 16;
  localparam int TIMEOUT   = 100;
  localparam int RST_PULSE = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_rdy = 1'b1;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       led;
  logic       target_rst_n;
  logic       busy;
  logic [4:0] len;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_tx  = -100;
  logic [7:0] tx_q[$];

  uart_cmd_engine #(
    .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .RST_PULSE(RST_PULSE), .ECHO_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_rdy(tx_rdy), .tx_en(tx_en), .tx_data(tx_data), .led(led),
    .target_rst_n(target_rst_n), .busy(busy), .len(len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Capture every transmit strobe and check its spacing.
  always @(negedge clk) begin
    if (tx_en === 1'b1) begin
      check("tx_gap_ge3", int'((cyc - last_tx) >= 3), 1);
      last_tx = cyc;
      tx_q.push_back(tx_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    check(tag, int'(busy), 0);
    tick(3);
  endtask

  task automatic check_str(input string tag, input string s);
    check({tag, "_count"}, tx_q.size(), s.len());
    for (int i = 0; i < s.len() && i < tx_q.size(); i++)
      check(tag, int'(tx_q[i]), int'(s[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int lo;
    tick(3);
    check("rst_tx_en", int'(tx_en), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_led", int'(led), 0);
    check("rst_target_rst_n", int'(target_rst_n), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_len", int'(len), 16);
    rst = 1'b0;
    tick(2);

    // Power-on secret readback
    tx_q.delete();
    send(8'h67);
    check("get_busy", int'(busy), 1);
    wait_idle("get_pow_idle");
    check_str("get_pow", "ABCDEFGHIJKLMNOP");

    // Short secret terminated by CR
    tx_q.delete();
    send(8'h73); send(8'h78); send(8'h79); send(8'h7A); send(8'h0D);
    wait_idle("set3_idle");
    check_str("set3_ack", "K");
    check("set3_len", int'(len), 3);
    tx_q.delete();
    send(8'h67);
    wait_idle("get3_idle");
    check_str("get3", "xyz");

    // Full buffer, following byte echoed from idle
    tx_q.delete();
    send(8'h73);
    for (int i = 0; i < 16; i++) send(8'h30 + 8'(i));
    check("full_busy", int'(busy), 1);
    check("full_len", int'(len), 16);
    wait_idle("full_idle");
    check_str("full_ack", "K");
    tx_q.delete();
    send(8'h40);
    wait_idle("echo40_idle");
    check_str("echo40", "@");
    tx_q.delete();
    send(8'h67);
    wait_idle("get16_idle");
    check_str("get16", "0123456789:;<=>?");

    // Timeout keeps the bytes already written, no ack
    tx_q.delete();
    send(8'h73); send(8'h61);
    tick(50);
    check("to_wait_busy", int'(busy), 1);
    tick(60);
    check("to_idle", int'(busy), 0);
    check("to_no_ack", tx_q.size(), 0);
    check("to_len", int'(len), 1);
    send(8'h67);
    wait_idle("get_a_idle");
    check_str("get_a", "a");

    // LED toggles and target reset pulse
    check("led0", int'(led), 0);
    send(8'h74); check("led1", int'(led), 1);
    send(8'h74); check("led2", int'(led), 0);
    send(8'h74); check("led3", int'(led), 1);
    send(8'h1B);
    check("pulse_busy", int'(busy), 0);
    lo = 0;
    while (target_rst_n === 1'b0 && lo < 100) begin
      lo++;
      tick(1);
    end
    check("pulse_len", lo, 16);
    send(8'h1B);
    tick(5);
    send(8'h1B);
    lo = 0;
    while (target_rst_n === 1'b0 && lo < 100) begin
      lo++;
      tick(1);
    end
    check("pulse_restart_len", lo, 16);

    // Echo waits for transmitter ready
    tx_q.delete();
    tx_rdy = 1'b0;
    send(8'h71);
    tick(50);
    check("rdy0_no_tx", tx_q.size(), 0);
    check("rdy0_busy", int'(busy), 1);
    tx_rdy = 1'b1;
    wait_idle("rdy1_idle");
    check_str("echo_q", "q");

    // Reset while waiting aborts the echo
    tx_q.delete();
    tx_rdy = 1'b0;
    send(8'h71);
    tick(20);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_tx_en", int'(tx_en), 0);
    check("abort_led", int'(led), 0);
    check("abort_len", int'(len), 16);
    check("abort_target_rst_n", int'(target_rst_n), 1);
    tx_rdy = 1'b1;
    tick(20);
    check("abort_no_tx", tx_q.size(), 0);
    check("abort_busy_after", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_engine.md
# uart_cmd_engine

Byte-level command engine sitting between `uart_rx_sol` and `uart_tx_sol` in the top-level design, replacing the fixed 16-byte get-only handler with a parametrised secret store. It decodes single-byte host commands (toggle LED, set secret, get secret, pulse target reset) and echoes unrecognised bytes. Set stores a variable-length secret of up to `DEPTH` bytes with terminator and timeout handling, and Get replays exactly the stored length.

## Interface
- `DEPTH`, 16: secret buffer size in bytes (2..256).
- `TIMEOUT`, 32000000: max idle clocks between bytes in SET before abort (≥2).
- `RST_PULSE`, 16: clocks `target_rst_n` is held low on reset command (≥1).
- `ECHO_EN`, 1: 1 = echo unrecognised IDLE bytes.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `rx_data` in 8: received byte.
- `tx_rdy` in 1: transmitter idle.
- `tx_en` out 1: one-cycle transmit strobe.
- `tx_data` out 8: byte to transmit, stable while `tx_en`=1.
- `led` out 1: LED state register.
- `target_rst_n` out 1: active-low reset to target board.
- `busy` out 1: 1 whenever state ≠ IDLE.
- `len` out clog2(DEPTH+1): currently stored secret length.

## Operation
- States: IDLE, SET, ACK, GET, ECHO.
- IDLE, on `rx_valid`:
  - 't' (0x74): `led` <= ~`led`.
  - 's' (0x73): write pointer <= 0, timeout counter <= 0, -> SET.
  - 'g' (0x67): read pointer <= 0. Goes to GET if `len`>0, else stays in IDLE.
  - 0x1B: `target_rst_n` low for exactly RST_PULSE clocks. A repeat 0x1B during the pulse restarts the count.
  - Any other byte: latched, then -> ECHO if ECHO_EN=1, else dropped.
- SET:
  - Every received byte except 0x0D is data, including 't', 'g' and 0x1B. Each is written to buf[ptr] and ptr increments.
  - 0x0D: `len` <= ptr, -> ACK.
  - Byte number DEPTH is written, then `len` <= DEPTH, -> ACK. A following 0x0D is then treated as an IDLE byte and echoed.
  - Timeout counter clears on each `rx_valid`. When it reaches TIMEOUT: `len` <= ptr (bytes already written are kept), -> IDLE, no ack.
- ACK: transmit 'K' (0x4B) once, then -> IDLE.
- GET: transmit buf[0..len-1] in order, then -> IDLE. `rx_valid` in GET, ACK or ECHO is dropped.
- ECHO: transmit the latched byte, then -> IDLE.
- Buffer is not cleared by `rst`. Power-on content is buf[i] = "A"+i. `rst` sets `len` <= DEPTH.

## Timing
- Reset values: `tx_en`=0, `tx_data`=0x00, `led`=0, `target_rst_n`=1, `busy`=0, `len`=DEPTH, state=IDLE.
- Command decode: state, `led` and `target_rst_n` update on the clock edge after `rx_valid`.
- Transmit handshake:
  - `tx_en` is asserted only in a cycle where `tx_rdy`=1 is sampled and the guard is clear.
  - After each `tx_en`, `tx_rdy` is ignored for 2 clocks (guard against transmitter ready lag).
  - Never two `tx_en` pulses closer than 3 clocks apart.
- First GET byte: `tx_en` no earlier than 1 clock after 'g' decode.
- `busy` goes low in the cycle after the final `tx_en` of GET, ACK or ECHO.
- Pointers wrap never. SET terminates at DEPTH, and GET stops at `len`.
- `rst` mid-SET or mid-GET: -> IDLE next edge, `tx_en`=0, pulse aborted (`target_rst_n`=1). Partially written bytes remain in the buffer.
- Simultaneous `rx_valid` and timeout expiry in SET: the byte is accepted and the counter clears.

## Test plan
- Reset then 'g' with `tx_rdy` tied 1 -> 16 `tx_en` pulses carrying "ABCDEFGHIJKLMNOP", ≥3 clocks apart; `busy` low afterwards.
- 's','x','y','z',0x0D then 'g' -> 'K' transmitted, `len`=3, get returns "xyz" only.
- 's' followed by 17 bytes 0x30..0x40 -> 'K' after the 16th byte, `len`=16. The 17th byte (0x40) is echoed from IDLE.
- 's','a' then TIMEOUT clocks with no input (TIMEOUT=100 in the bench) -> back to IDLE, no 'K', `len`=1. 'g' returns "a".
- 't','t','t' -> `led` 0->1->0->1. Then 0x1B -> `target_rst_n` low exactly RST_PULSE (16) clocks.
- 'q' with `tx_rdy` held 0 for 50 clocks -> no `tx_en` until `tx_rdy` rises, then one pulse with `tx_data`=0x71. Repeat with `rst` asserted during the wait -> no pulse, state IDLE.
